sub_serial_ctrl: RTL and testbench

SUB_SERIAL_CTRL -- requirements
Module: sub_serial_ctrl

---
 rtl/sub_serial_ctrl.sv | 91 +++++++++
 tb/tb_sub_serial_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sub_serial_ctrl.sv
// rtl/sub_serial_ctrl.sv - bit-serial subtractor, LSB first, one bit per clock
// Produces a-b mod 2^WIDTH plus an unsigned borrow and a signed-overflow flag after WIDTH RUN cycles.
module sub_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             brw;
    logic             a_msb;
    logic             b_msb;

    logic x, y, d, bout;
    assign x    = opa[0];
    assign y    = opb[0];
    assign d    = x ^ y ^ brw;
    assign bout = (~x & y) | (~(x ^ y) & brw);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            brw        <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Difference bits enter from the top so bit 0 ends up at diff[0] after WIDTH shifts.
                    diff <= {d, diff[WIDTH-1:1]};
                    opa  <= opa >> 1;
                    opb  <= opb >> 1;
                    brw  <= bout;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        borrow_out <= bout;
                        ovf        <= (a_msb ^ b_msb) & (d ^ a_msb);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_serial_ctrl.sv
// tb/tb_sub_serial_ctrl.sv - directed vector bench for sub_serial_ctrl (WIDTH=8)
module tb_sub_serial_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [7:0] diff;
    logic       borrow_out, ovf, busy, done;

    int tests = 0;
    int failures = 0;
    int cyc = 0;

    sub_serial_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff), .borrow_out(borrow_out), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] ed;
        logic       eb;
        logic       eo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check({tag, " done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ed,
                          input logic eb, input logic eo, input string tag);
        int n = 0;
        a = va;
        b = vb;
        start = 1'b1;
        step();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, " busy_cycles"}, n, 32'd8);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " diff"}, {24'd0, diff}, {24'd0, ed});
        check({tag, " borrow"}, {31'd0, borrow_out}, {31'd0, eb});
        check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        step();
        check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, " hold_diff"}, {24'd0, diff}, {24'd0, ed});
    endtask

    initial begin
        int pulses;
        int t1;
        int t2;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
        vecs[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
        vecs[9] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};

        repeat (3) step();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset diff", {24'd0, diff}, 32'd0);
        check("reset borrow", {31'd0, borrow_out}, 32'd0);
        check("reset ovf", {31'd0, ovf}, 32'd0);

        // First start rides on the very first edge with rst low.
        rst = 1'b0;
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].eo,
                   $sformatf("vec%0d", i));

        // Second start during RUN must be ignored.
        a = 8'h10; b = 8'h01; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        step();
        start = 1'b0;
        wait_done("ignore");
        check("ignore diff", {24'd0, diff}, 32'h0F);
        check("ignore borrow", {31'd0, borrow_out}, 32'd0);
        check("ignore ovf", {31'd0, ovf}, 32'd0);
        pulses = 0;
        repeat (15) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("ignore extra_done", pulses, 32'd0);
        check("ignore busy_after", {31'd0, busy}, 32'd0);

        // Reset in the middle of RUN aborts without a done pulse.
        a = 8'h80; b = 8'h01; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort diff", {24'd0, diff}, 32'd0);
        check("abort borrow", {31'd0, borrow_out}, 32'd0);
        check("abort ovf", {31'd0, ovf}, 32'd0);
        pulses = 0;
        repeat (12) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("abort no_done", pulses, 32'd0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "after_abort");

        // Back-to-back issue in the IDLE cycle right after done.
        a = 8'h05; b = 8'h03; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("b2b first");
        t1 = cyc;
        check("b2b first diff", {24'd0, diff}, 32'h02);
        step();
        a = 8'h00; b = 8'h01; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("b2b second");
        t2 = cyc;
        check("b2b interval", t2 - t1, 32'd10);
        check("b2b second diff", {24'd0, diff}, 32'hFF);
        check("b2b second borrow", {31'd0, borrow_out}, 32'd1);
        check("b2b second ovf", {31'd0, ovf}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
